// File: rtl/button_event_arbiter.sv
// Merges single-cycle button press pulses onto one valid/ready event channel.
// Presses stay pending until accepted; competing presses are served round-robin.
module button_event_arbiter #(
  parameter int N_BTN  = 4,
  parameter int CODE_W = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [N_BTN-1:0]  BtnPulse,
  input  logic              EvtReady,
  output logic              EvtValid,
  output logic [CODE_W-1:0] EvtCode,
  output logic              EvtOverrun,
  output logic [N_BTN-1:0]  PendingMask
);

  // Handshake: an event moves when EvtValid && EvtReady at a rising edge;
  // EvtValid/EvtCode stay stable until then and EvtValid never drops without it.
  typedef enum logic [1:0] {
    S_Idle  = 2'b00,
    S_Offer = 2'b01
  } state_t;

  state_t              state, state_nxt;
  logic [N_BTN-1:0]    pending, pending_nxt, grant_vec;
  logic [CODE_W-1:0]   last_grant, sel;
  logic                found, do_grant, overrun_nxt;

  // Round-robin search starting just after the last granted index.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    for (int k = 1; k <= N_BTN; k++) begin
      int idx;
      idx = (int'(last_grant) + k) % N_BTN;
      if (!found && pending[idx]) begin
        found = 1'b1;
        sel   = CODE_W'(idx);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    do_grant  = 1'b0;
    case (state)
      S_Idle: begin
        if (found) begin
          do_grant  = 1'b1;
          state_nxt = S_Offer;
        end
      end
      S_Offer: begin
        if (EvtReady) begin
          if (found) do_grant = 1'b1;
          else       state_nxt = S_Idle;
        end
      end
      default: state_nxt = S_Idle;
    endcase
  end

  always_comb begin
    grant_vec = '0;
    for (int i = 0; i < N_BTN; i++) begin
      grant_vec[i] = do_grant && (sel == CODE_W'(i));
    end
  end

  // A press landing on the edge its line is granted simply re-arms the bit.
  assign pending_nxt = (pending & ~grant_vec) | BtnPulse;
  assign overrun_nxt = |(BtnPulse & pending & ~grant_vec);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state      <= S_Idle;
      pending    <= '0;
      last_grant <= CODE_W'(N_BTN - 1);
      EvtCode    <= '0;
      EvtOverrun <= 1'b0;
    end else begin
      state      <= state_nxt;
      pending    <= pending_nxt;
      EvtOverrun <= overrun_nxt;
      if (do_grant) begin
        EvtCode    <= sel;
        last_grant <= sel;
      end
    end
  end

  assign EvtValid    = (state == S_Offer);
  assign PendingMask = pending;

endmodule

// File: tb/tb_button_event_arbiter.sv
// Directed vector bench for button_event_arbiter with an accepted-event scoreboard.
module tb_button_event_arbiter;

  localparam int N_BTN  = 4;
  localparam int CODE_W = 2;

  logic              Clk;
  logic              Reset;
  logic [N_BTN-1:0]  BtnPulse;
  logic              EvtReady;
  logic              EvtValid;
  logic [CODE_W-1:0] EvtCode;
  logic              EvtOverrun;
  logic [N_BTN-1:0]  PendingMask;

  int n_checks = 0;
  int n_fail   = 0;

  logic [CODE_W-1:0] exp_q[$];

  typedef struct {
    logic [N_BTN-1:0]  btn;
    logic              rdy;
    logic              exp_valid;
    logic [CODE_W-1:0] exp_code;
    logic              exp_ov;
    logic [N_BTN-1:0]  exp_pend;
  } vec_t;

  vec_t vecs[$];

  button_event_arbiter #(.N_BTN(N_BTN), .CODE_W(CODE_W)) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .BtnPulse    (BtnPulse),
    .EvtReady    (EvtReady),
    .EvtValid    (EvtValid),
    .EvtCode     (EvtCode),
    .EvtOverrun  (EvtOverrun),
    .PendingMask (PendingMask)
  );

  // clock / reset
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic [N_BTN-1:0] btn, input logic rdy, input logic v,
                     input logic [CODE_W-1:0] code, input logic ov, input logic [N_BTN-1:0] pend);
    vec_t e;
    e.btn = btn; e.rdy = rdy; e.exp_valid = v; e.exp_code = code; e.exp_ov = ov; e.exp_pend = pend;
    vecs.push_back(e);
  endtask

  task automatic check_outputs(input string tag, input logic v, input logic [CODE_W-1:0] code,
                               input logic ov, input logic [N_BTN-1:0] pend);
    check({tag, ".valid"},   32'(EvtValid),    32'(v));
    check({tag, ".code"},    32'(EvtCode),     32'(code));
    check({tag, ".overrun"}, 32'(EvtOverrun),  32'(ov));
    check({tag, ".pending"}, 32'(PendingMask), 32'(pend));
  endtask

  // scoreboard: every accepted event must match the next expected code
  always @(posedge Clk) begin
    if (Reset && EvtValid && EvtReady) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL accept: got unexpected code %0d, required no event", EvtCode);
      end else begin
        logic [CODE_W-1:0] e;
        e = exp_q.pop_front();
        if (EvtCode !== e) begin
          n_fail++;
          $display("FAIL accept: got code %0d, required %0d", EvtCode, e);
        end
      end
    end
  end

  initial begin
    // simultaneous from reset
    add(4'b1011, 1, 0, 0, 0, 4'b1011);
    add(4'b0000, 1, 1, 0, 0, 4'b1010);
    add(4'b0000, 1, 1, 1, 0, 4'b1000);
    add(4'b0000, 1, 1, 3, 0, 4'b0000);
    add(4'b0000, 1, 0, 3, 0, 4'b0000);
    // round robin: grant 1 then 1001 -> 3 before 0
    add(4'b0010, 1, 0, 3, 0, 4'b0010);
    add(4'b1001, 1, 1, 1, 0, 4'b1001);
    add(4'b0000, 1, 1, 3, 0, 4'b0001);
    add(4'b0000, 1, 1, 0, 0, 4'b0000);
    add(4'b0000, 1, 0, 0, 0, 4'b0000);
    // single press
    add(4'b0100, 1, 0, 0, 0, 4'b0100);
    add(4'b0000, 1, 1, 2, 0, 4'b0000);
    add(4'b0000, 1, 0, 2, 0, 4'b0000);
    // backpressure, then overrun on line 1
    add(4'b0100, 0, 0, 2, 0, 4'b0100);
    add(4'b0000, 0, 1, 2, 0, 4'b0000);
    for (int i = 0; i < 3; i++) add(4'b0000, 0, 1, 2, 0, 4'b0000);
    add(4'b0010, 0, 1, 2, 0, 4'b0010);
    add(4'b0000, 0, 1, 2, 0, 4'b0010);
    add(4'b0000, 0, 1, 2, 0, 4'b0010);
    add(4'b0010, 0, 1, 2, 1, 4'b0010);
    for (int i = 0; i < 3; i++) add(4'b0000, 0, 1, 2, 0, 4'b0010);
    add(4'b0000, 1, 1, 1, 0, 4'b0000);
    add(4'b0000, 1, 0, 1, 0, 4'b0000);
    add(4'b0000, 1, 0, 1, 0, 4'b0000);
    // same-edge re-press of line 0
    add(4'b0001, 1, 0, 1, 0, 4'b0001);
    add(4'b0001, 1, 1, 0, 0, 4'b0001);
    add(4'b0000, 1, 1, 0, 0, 4'b0000);
    add(4'b0000, 1, 0, 0, 0, 4'b0000);

    exp_q = '{2'd0, 2'd1, 2'd3, 2'd1, 2'd3, 2'd0, 2'd2, 2'd2, 2'd1, 2'd0, 2'd0};

    Reset = 1'b0; BtnPulse = '0; EvtReady = 1'b0;
    #12;
    check_outputs("reset", 0, 0, 0, 4'b0000);
    Reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      BtnPulse = vecs[i].btn;
      EvtReady = vecs[i].rdy;
      step();
      check_outputs($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_code,
                    vecs[i].exp_ov, vecs[i].exp_pend);
    end
    BtnPulse = '0;
    EvtReady = 1'b0;
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    // asynchronous reset while an event is offered and another is pending
    BtnPulse = 4'b1000; step();
    BtnPulse = 4'b0100; step();
    BtnPulse = '0;
    check_outputs("pre_reset", 1, 3, 0, 4'b0100);
    #2 Reset = 1'b0;
    #1 check_outputs("async_reset", 0, 0, 0, 4'b0000);
    step();
    Reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_outputs($sformatf("post_reset%0d", i), 0, 0, 0, 4'b0000);
    end

    // pointer restarts at index 0 after reset
    exp_q.push_back(2'd1);
    exp_q.push_back(2'd2);
    EvtReady = 1'b1;
    BtnPulse = 4'b0110; step();
    BtnPulse = '0;
    check_outputs("rr_reset0", 0, 0, 0, 4'b0110);
    step(); check_outputs("rr_reset1", 1, 1, 0, 4'b0100);
    step(); check_outputs("rr_reset2", 1, 2, 0, 4'b0000);
    step(); check_outputs("rr_reset3", 0, 2, 0, 4'b0000);
    check("queue_drained_end", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/button_event_arbiter.md
Name: button_event_arbiter

Overview:
- Collects single-cycle press pulses from N button shaper instances and merges them onto one shared event channel.
- Each press is latched as pending until the downstream consumer accepts it.
- Simultaneous or overlapping presses are served round-robin, so no press is lost unless the same button fires again while its press is still pending.
- Sits between the bank of button shapers and the control FSM that consumes button events (lock/entry/menu logic).

Parameters:
- N_BTN, 4, number of button pulse inputs (2..8).
- CODE_W, 2, width of event code; must satisfy 2**CODE_W >= N_BTN.

Ports:
- Clk  input  1  system clock, rising-edge active.
- Reset  input  1  asynchronous, active-low reset.
- BtnPulse  input  N_BTN  one-cycle-high press pulses, bit i from shaper i, synchronous to Clk.
- EvtReady  input  1  consumer can accept an event this cycle.
- EvtValid  output  1  an event is offered on EvtCode.
- EvtCode  output  CODE_W  index of the button whose press is offered.
- EvtOverrun  output  1  one-cycle pulse: a press arrived on a line whose previous press was still pending; the new press is dropped.
- PendingMask  output  N_BTN  current pending bits; for debug/LEDs.

Behaviour:
- Reset (Reset=0, async):
  - EvtValid=0, EvtCode=0, EvtOverrun=0, PendingMask=0, state=S_Idle.
  - Round-robin pointer LastGrant=N_BTN-1, so the first search starts at index 0.
  - Reset mid-offer discards the offered event and all pending presses.
- Pending latch: at each rising edge, for each bit i:
  - if BtnPulse[i]=1 and pending[i]=0: pending[i] is set;
  - if BtnPulse[i]=1 and pending[i]=1 and pending[i] is not being granted this edge: pending[i] stays 1 and EvtOverrun=1 for the following cycle only;
  - if BtnPulse[i]=1 on the same edge that grants pending[i]: pending[i] ends 1 (new press wins), no overrun.
- Grant select: first index with pending=1, searching LastGrant+1, LastGrant+2, ... modulo N_BTN. Uses registered pending bits only; no combinational bypass from BtnPulse.
- S_Idle:
  - EvtValid=0.
  - If any pending bit is set at an edge: load EvtCode=selected, clear that pending bit, LastGrant=selected, go to S_Offer (EvtValid=1 from the next cycle).
  - Otherwise stay in S_Idle.
- S_Offer:
  - EvtValid=1; EvtCode and EvtValid held stable until an edge with EvtReady=1.
  - At an edge with EvtReady=1:
    - if another pending bit is set: load the next grant exactly as in S_Idle and stay in S_Offer, so back-to-back events have no idle bubble;
    - otherwise go to S_Idle with EvtValid=0.
  - EvtReady while in S_Idle is ignored.
- Latency: a pulse sampled at edge k reaches EvtValid=1 after edge k+1, provided no other event is ahead of it.
- A button whose press is currently held in the output register (not pending) may register a new press without overrun.
- Illegal state encoding returns to S_Idle at the next edge.
- EvtCode keeps its last value while EvtValid=0.
- Only EvtOverrun is a pulse; all other outputs are registered levels.

Test Plan:
- Reset behaviour: drive pulses and hold EvtReady=0 so an event is being offered, then assert Reset=0 between clock edges. Required: EvtValid=0, PendingMask=0, EvtCode=0 immediately, without waiting for a clock edge. After release, nothing is offered until a new pulse.
- Single press (N_BTN=4), EvtReady=1: BtnPulse=0100 for one cycle at edge k. Required: PendingMask=0100 after k; EvtValid=1 and EvtCode=2 for exactly one cycle after k+1; then idle.
- Simultaneous presses from reset: BtnPulse=1011 for one cycle, EvtReady=1. Required: EvtCode 0, 1, 3 on three consecutive valid cycles, then EvtValid=0.
- Round-robin order: grant code 1, then pulse 1001 with EvtReady=1. Required: code 3 before code 0.
- Backpressure and overrun: EvtReady=0 for 10 cycles with code 2 offered. Required: EvtValid and EvtCode=2 stable throughout. Then pulse line 1 twice, 3 cycles apart. Required: PendingMask=0010; EvtOverrun=1 for exactly one cycle after the second pulse; only one code-1 event is delivered after EvtReady=1.
- Same-edge re-press: pulse line 0 on the edge that grants pending[0]. Required: pending[0] remains 1, no overrun, and two code-0 events are delivered in total.
